// File: rtl/wide_sum_sub_seq_if.sv
// Operand/result bundle for the slice-serial wide adder/subtractor.
// Latency: none (wires only); the consumer defines timing.
// Backpressure: none; starts offered while the engine is busy are dropped.
// Ports: in_start/in_op/in_bit/in_a/in_b driven by the requester (master),
//        out_busy/out_done/out_data/out_bit driven by the engine (slave).
interface wide_sum_sub_seq_if #(
  parameter int WIDTH  = 4,
  parameter int SLICES = 4
);
  localparam int N = WIDTH * SLICES;

  logic         in_start;
  logic         in_op;
  logic         in_bit;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_busy;
  logic         out_done;
  logic [N-1:0] out_data;
  logic         out_bit;

  modport master (
    output in_start, in_op, in_bit, in_a, in_b,
    input  out_busy, out_done, out_data, out_bit
  );

  modport slave (
    input  in_start, in_op, in_bit, in_a, in_b,
    output out_busy, out_done, out_data, out_bit
  );
endinterface

// File: rtl/wide_sum_sub_seq.sv
// Slice-serial N-bit add/subtract, one WIDTH-bit slice per clock, LSB first.
// Latency: SLICES cycles from the accepting edge to the one-cycle out_done.
// Backpressure: in_start is taken only in IDLE or DONE; ignored while busy.
// Ports: in_clk, in_rst (sync, active-high); bus (slave modport) carries the
//        start/op/carry/operands in and busy/done/result/carry-out back.
module wide_sum_sub_seq #(
  parameter int WIDTH  = 4,
  parameter int SLICES = 4
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  wide_sum_sub_seq_if.slave    bus
);
  localparam int N  = WIDTH * SLICES;
  localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           op_q, op_d;
  logic           c_q, c_d;
  logic [N-1:0]   res_q, res_d;
  logic [N-1:0]   out_data_q, out_data_d;
  logic           out_bit_q, out_bit_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [WIDTH-1:0] a_k, b_k;
  logic [WIDTH:0]   slice_r;
  int               lo;

  // Slice arithmetic at WIDTH+1 bits: the top bit is the carry for add and,
  // because the difference wraps negative exactly when a_k < b_k + c, the
  // borrow for subtract.
  always_comb begin
    lo  = int'(k_q) * WIDTH;
    a_k = a_q[lo +: WIDTH];
    b_k = b_q[lo +: WIDTH];
    if (op_q) begin
      slice_r = {1'b0, a_k} - {1'b0, b_k} - {{WIDTH{1'b0}}, c_q};
    end else begin
      slice_r = {1'b0, a_k} + {1'b0, b_k} + {{WIDTH{1'b0}}, c_q};
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    c_d        = c_q;
    res_d      = res_q;
    out_data_d = out_data_q;
    out_bit_d  = out_bit_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (bus.in_start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          k_d     = '0;
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          op_d    = bus.in_op;
          c_d     = bus.in_bit;
        end
      end
      RUN: begin
        res_d[lo +: WIDTH] = slice_r[WIDTH-1:0];
        c_d                = slice_r[WIDTH];
        if (k_q == K_LAST) begin
          // Publish the full result only once every slice is written.
          state_d    = DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          out_data_d = res_d;
          out_bit_d  = slice_r[WIDTH];
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      c_q        <= 1'b0;
      res_q      <= '0;
      out_data_q <= '0;
      out_bit_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      c_q        <= c_d;
      res_q      <= res_d;
      out_data_q <= out_data_d;
      out_bit_q  <= out_bit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.out_busy = busy_q;
  assign bus.out_done = done_q;
  assign bus.out_data = out_data_q;
  assign bus.out_bit  = out_bit_q;
endmodule
